round_controller: RTL and testbench

ROUND_CONTROLLER -- requirements
Module: round_controller

---
 rtl/simon_pkg.sv | 17 +
 rtl/round_controller_if.sv | 24 ++
 rtl/round_controller_dwell_timer.sv | 21 ++
 rtl/round_controller.sv | 117 +++++++++++
 tb/tb_round_controller.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared Simon-game types: colour encoding, level limit and round FSM states.
package simon_pkg;
  typedef enum logic [1:0] {
    RED    = 2'd0,
    GREEN  = 2'd1,
    BLUE   = 2'd2,
    YELLOW = 2'd3
  } color_e;

  localparam int MAX_LEVEL = 8;
  localparam int IDX_W     = 3;
  localparam int LEVEL_W   = 4;

  typedef enum logic [2:0] {
    IDLE, FETCH, SHOW_ON, SHOW_OFF, IN_FETCH, WAIT_IN, WIN, LOSE
  } state_e;
endpackage

// File: rtl/round_controller_if.sv
// Round controller bus: game control, pattern memory read port, buttons, display and status.
interface round_controller_if;
  logic       start;
  logic       load_done;
  logic [2:0] mem_addr;
  logic [1:0] mem_color;
  logic       btn_valid;
  logic [1:0] btn_color;
  logic       led_on;
  logic [1:0] led_color;
  logic [3:0] level;
  logic       busy;
  logic       win;
  logic       lose;

  modport master (
    input  start, load_done, mem_color, btn_valid, btn_color,
    output mem_addr, led_on, led_color, level, busy, win, lose
  );
  modport slave (
    output start, load_done, mem_color, btn_valid, btn_color,
    input  mem_addr, led_on, led_color, level, busy, win, lose
  );
endinterface

// File: rtl/round_controller_dwell_timer.sv
// Down-counter for lit/dark dwell phases; done while the count sits at zero.
module dwell_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)                   cnt <= '0;
    else if (load)                cnt <= load_val;
    else if (count && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/round_controller.sv
// Simon round sequencer: replays the pattern up to the current level, then checks player input.
module round_controller #(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000,
  parameter int MAX_LEVEL  = simon_pkg::MAX_LEVEL
) (
  input logic               clk,
  input logic               reset,
  round_controller_if.master bus
);
  import simon_pkg::*;

  localparam int DWELL_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int DW        = $clog2(DWELL_MAX + 1);
  localparam logic [DW-1:0]      ON_LOAD    = DW'(ON_CYCLES - 1);
  localparam logic [DW-1:0]      OFF_LOAD   = DW'(OFF_CYCLES - 1);
  localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(MAX_LEVEL);

  state_e           state;
  logic [IDX_W-1:0] idx;
  color_e           exp_color;
  logic             tmr_load, tmr_count, tmr_done, at_last;
  logic [DW-1:0]    tmr_val;

  assign at_last = ({1'b0, idx} == bus.level - 4'd1);

  // Timer is held at the lit reload outside the display phases, so SHOW_ON
  // always starts fresh; it switches to the dark reload as SHOW_ON expires.
  assign tmr_load  = (state != SHOW_ON && state != SHOW_OFF) || (state == SHOW_ON && tmr_done);
  assign tmr_val   = (state == SHOW_ON) ? OFF_LOAD : ON_LOAD;
  assign tmr_count = (state == SHOW_ON) || (state == SHOW_OFF);

  dwell_timer #(.W(DW)) u_dwell (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .count    (tmr_count),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= IDLE;
      idx           <= '0;
      exp_color     <= RED;
      bus.mem_addr  <= '0;
      bus.led_on    <= 1'b0;
      bus.led_color <= '0;
      bus.level     <= '0;
      bus.busy      <= 1'b0;
      bus.win       <= 1'b0;
      bus.lose      <= 1'b0;
    end else begin
      case (state)
        IDLE, WIN, LOSE:
          if (bus.start && bus.load_done) begin
            state        <= FETCH;
            bus.level    <= 4'd1;
            idx          <= '0;
            bus.mem_addr <= '0;
            bus.win      <= 1'b0;
            bus.lose     <= 1'b0;
            bus.busy     <= 1'b1;
          end
        FETCH: begin
          bus.led_color <= bus.mem_color;
          bus.led_on    <= 1'b1;
          state         <= SHOW_ON;
        end
        SHOW_ON:
          if (tmr_done) begin
            bus.led_on <= 1'b0;
            state      <= SHOW_OFF;
          end
        SHOW_OFF:
          if (tmr_done) begin
            if (at_last) begin
              idx          <= '0;
              bus.mem_addr <= '0;
              state        <= IN_FETCH;
            end else begin
              idx          <= idx + 3'd1;
              bus.mem_addr <= idx + 3'd1;
              state        <= FETCH;
            end
          end
        IN_FETCH: begin
          exp_color <= color_e'(bus.mem_color);
          state     <= WAIT_IN;
        end
        WAIT_IN:
          if (bus.btn_valid) begin
            if (bus.btn_color != exp_color) begin
              state    <= LOSE;
              bus.lose <= 1'b1;
              bus.busy <= 1'b0;
            end else if (!at_last) begin
              idx          <= idx + 3'd1;
              bus.mem_addr <= idx + 3'd1;
              state        <= IN_FETCH;
            end else if (bus.level == LAST_LEVEL) begin
              state    <= WIN;
              bus.win  <= 1'b1;
              bus.busy <= 1'b0;
            end else begin
              bus.level    <= bus.level + 4'd1;
              idx          <= '0;
              bus.mem_addr <= '0;
              state        <= FETCH;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with ON=4, OFF=2 and pattern 0,1,2,3,0,1,2,3.
module tb_round_controller;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  round_controller_if bus ();

  round_controller #(.ON_CYCLES(4), .OFF_CYCLES(2), .MAX_LEVEL(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [1:0] mem [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
  assign bus.mem_color = mem[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [1:0] c);
    bus.btn_valid = 1'b1;
    bus.btn_color = c;
    tick();
    bus.btn_valid = 1'b0;
  endtask

  task automatic show(input int i, input int lvl);
    chk("fetch_addr", 32'(bus.mem_addr), 32'(i));
    chk("fetch_busy", 32'(bus.busy), 32'(1));
    chk("fetch_level", 32'(bus.level), 32'(lvl));
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("on_led", 32'(bus.led_on), 32'(1));
      chk("on_color", 32'(bus.led_color), 32'(mem[i]));
      tick();
    end
    for (int c = 0; c < 2; c++) begin
      chk("off_led", 32'(bus.led_on), 32'(0));
      tick();
    end
  endtask

  task automatic replay(input int lvl);
    for (int i = 0; i < lvl; i++) show(i, lvl);
    chk("in_fetch_addr", 32'(bus.mem_addr), 32'(0));
    tick();
  endtask

  task automatic play_level(input int lvl);
    replay(lvl);
    for (int i = 0; i < lvl; i++) begin
      press(mem[i]);
      if (i < lvl - 1) begin
        chk("in_addr", 32'(bus.mem_addr), 32'(i + 1));
        chk("in_lose", 32'(bus.lose), 32'(0));
        tick();
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_led_on"}, 32'(bus.led_on), 32'(0));
    chk({tag, "_led_color"}, 32'(bus.led_color), 32'(0));
    chk({tag, "_level"}, 32'(bus.level), 32'(0));
    chk({tag, "_busy"}, 32'(bus.busy), 32'(0));
    chk({tag, "_win"}, 32'(bus.win), 32'(0));
    chk({tag, "_lose"}, 32'(bus.lose), 32'(0));
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(0));
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.load_done = 1'b0;
    bus.btn_valid = 1'b0;
    bus.btn_color = 2'd0;
    reset = 1'b0;
    repeat (2) tick();
    chk_all_zero("reset");
    checks++;
    if (bus.level !== 4'd0) begin errors++; $error("FAIL reset_level_inline"); end
    reset = 1'b1;
    tick();

    do_start();
    chk("noload_busy", 32'(bus.busy), 32'(0));
    chk("noload_level", 32'(bus.level), 32'(0));
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $error("FAIL noload_busy_inline"); end
    tick();
    chk("noload_busy2", 32'(bus.busy), 32'(0));
    press(2'd3);
    chk("idle_btn_lose", 32'(bus.lose), 32'(0));

    bus.load_done = 1'b1;
    do_start();
    show(0, 1);
    chk("l1_in_fetch_addr", 32'(bus.mem_addr), 32'(0));
    do_start();
    chk("busy_start_level", 32'(bus.level), 32'(1));
    repeat (5) begin
      tick();
      chk("wait_busy", 32'(bus.busy), 32'(1));
      chk("wait_led", 32'(bus.led_on), 32'(0));
    end
    press(2'd0);
    chk("l1_up_level", 32'(bus.level), 32'(2));

    replay(2);
    press(2'd0);
    chk("l2_in_addr", 32'(bus.mem_addr), 32'(1));
    tick();
    press(2'd3);
    chk("lose_flag", 32'(bus.lose), 32'(1));
    chk("lose_busy", 32'(bus.busy), 32'(0));
    chk("lose_win", 32'(bus.win), 32'(0));
    chk("lose_level", 32'(bus.level), 32'(2));
    checks++;
    if (bus.lose !== 1'b1) begin errors++; $error("FAIL lose_flag_inline"); end
    press(2'd0);
    chk("lose_sticky", 32'(bus.lose), 32'(1));

    do_start();
    chk("restart_lose", 32'(bus.lose), 32'(0));
    chk("restart_level", 32'(bus.level), 32'(1));
    for (int lvl = 1; lvl <= 8; lvl++) begin
      play_level(lvl);
      if (lvl < 8) chk("game_level", 32'(bus.level), 32'(lvl + 1));
    end
    chk("win_flag", 32'(bus.win), 32'(1));
    chk("win_level", 32'(bus.level), 32'(8));
    chk("win_busy", 32'(bus.busy), 32'(0));
    chk("win_lose", 32'(bus.lose), 32'(0));
    checks++;
    if (bus.win !== 1'b1) begin errors++; $error("FAIL win_flag_inline"); end
    tick();
    chk("win_sticky", 32'(bus.win), 32'(1));

    do_start();
    chk("rewin_win", 32'(bus.win), 32'(0));
    chk("rewin_level", 32'(bus.level), 32'(1));
    repeat (5) tick();
    chk("off_phase_led", 32'(bus.led_on), 32'(0));
    press(2'd3);
    chk("off_press_led", 32'(bus.led_on), 32'(0));
    chk("off_press_lose", 32'(bus.lose), 32'(0));
    tick();
    tick();
    chk("off_press_busy", 32'(bus.busy), 32'(1));
    press(2'd0);
    chk("off_press_level", 32'(bus.level), 32'(2));
    chk("off_press_lose2", 32'(bus.lose), 32'(0));

    show(0, 2);
    tick();
    tick();
    chk("pre_rst_led", 32'(bus.led_on), 32'(1));
    chk("pre_rst_color", 32'(bus.led_color), 32'(1));
    chk("pre_rst_addr", 32'(bus.mem_addr), 32'(1));
    reset = 1'b0;
    bus.start = 1'b1;
    bus.btn_valid = 1'b1;
    bus.btn_color = 2'd3;
    tick();
    chk_all_zero("midrst");
    reset = 1'b1;
    bus.start = 1'b0;
    bus.btn_valid = 1'b0;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 32'(0));
    chk("post_rst_level", 32'(bus.level), 32'(0));
    checks++;
    if (bus.led_on !== 1'b0) begin errors++; $error("FAIL post_rst_led_inline"); end
    do_start();
    show(0, 1);
    chk("post_rst_in_addr", 32'(bus.mem_addr), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
